alu_cmd_sequencer: RTL and testbench

- Command-side driver for the N-bit combinational ALU: accepts operation requests over a valid/ready handshake and drives the ALU operands and 3-bit select.
- Samples the ALU result and its Cout/NegFlag/zeroFlag one cycle later and returns them over a valid/ready response handshake.
- Holds a chaining accumulator so a command can reuse the previous result as operand A.
- Keeps completed-operation and illegal-opcode counters.

---
 rtl/alu_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for an N-bit combinational ALU: accepts one operation, drives the
// ALU for a cycle, captures the result with its flags and returns it over a handshake.
module alu_cmd_sequencer #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_a,
    input  logic [N-1:0]  cmd_b,
    input  logic          cmd_chain,
    output logic [N-1:0]  alu_a,
    output logic [N-1:0]  alu_b,
    output logic [2:0]    alu_sel,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_cout,
    input  logic          alu_neg,
    input  logic          alu_zero,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_result,
    output logic          rsp_cout,
    output logic          rsp_neg,
    output logic          rsp_zero,
    output logic          rsp_err,
    output logic [CW-1:0] op_count,
    output logic [CW-1:0] err_count,
    output logic [1:0]    dbg_state
);

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready. Neither side
    // may withdraw or change its payload while valid is high and ready is low.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    state_t         state_q;
    logic           cmd_ready_q;
    logic           rsp_valid_q;
    logic [N-1:0]   alu_a_q;
    logic [N-1:0]   alu_b_q;
    logic [2:0]     alu_sel_q;
    logic           err_q;
    logic [N-1:0]   acc_q;
    logic [N-1:0]   rsp_result_q;
    logic           rsp_cout_q;
    logic           rsp_neg_q;
    logic           rsp_zero_q;
    logic           rsp_err_q;
    logic [CW-1:0]  op_count_q;
    logic [CW-1:0]  err_count_q;

    logic [CW-1:0]  op_count_d;
    logic [CW-1:0]  err_count_d;

    // op_count wraps naturally; err_count sticks at all-ones.
    always_comb begin
        op_count_d  = op_count_q + CW'(1);
        err_count_d = (&err_count_q) ? err_count_q : err_count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            err_q        <= 1'b0;
            acc_q        <= '0;
            rsp_result_q <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_neg_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
            err_count_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        alu_a_q     <= cmd_chain ? acc_q : cmd_a;
                        alu_b_q     <= cmd_b;
                        alu_sel_q   <= cmd_op;
                        err_q       <= (cmd_op == OP_ILLEGAL);
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable for this whole cycle; sample its outputs.
                    if (err_q) begin
                        rsp_result_q <= '0;
                        rsp_cout_q   <= 1'b0;
                        rsp_neg_q    <= 1'b0;
                        rsp_zero_q   <= 1'b0;
                        rsp_err_q    <= 1'b1;
                    end else begin
                        rsp_result_q <= alu_result;
                        rsp_cout_q   <= alu_cout;
                        rsp_neg_q    <= alu_neg;
                        rsp_zero_q   <= alu_zero;
                        rsp_err_q    <= 1'b0;
                        acc_q        <= alu_result;
                    end
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        op_count_q  <= op_count_d;
                        if (rsp_err_q) begin
                            err_count_q <= err_count_d;
                        end
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_result = rsp_result_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_neg    = rsp_neg_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign op_count   = op_count_q;
    assign err_count  = err_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (CW=8 and CW=2) share the command/response
// stimulus, each drives its own copy of a behavioural 4-bit ALU.
module tb_alu_cmd_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_chain;
    logic       rsp_ready;

    logic       cmd_ready, rsp_valid, rsp_cout, rsp_neg, rsp_zero, rsp_err;
    logic [3:0] alu_a, alu_b, rsp_result, alu_result;
    logic [2:0] alu_sel;
    logic       alu_cout, alu_neg, alu_zero;
    logic [7:0] op_count, err_count;
    logic [1:0] dbg_state;

    logic       cmd_ready2, rsp_valid2, rsp_cout2, rsp_neg2, rsp_zero2, rsp_err2;
    logic [3:0] alu_a2, alu_b2, rsp_result2, alu_result2;
    logic [2:0] alu_sel2;
    logic       alu_cout2, alu_neg2, alu_zero2;
    logic [1:0] op_count2, err_count2;
    logic [1:0] dbg_state2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    // ALU: returns {cout, neg, zero, result}; select 111 produces deliberate garbage.
    function automatic logic [6:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] sel);
        logic [4:0] w;
        logic [3:0] r;
        logic       c;
        r = '0;
        c = 1'b0;
        case (sel)
            3'd0: begin w = {1'b0, a} + {1'b0, b};          r = w[3:0]; c = w[4]; end
            3'd1: begin w = {1'b0, a} + {1'b0, ~b} + 5'd1;  r = w[3:0]; c = w[4]; end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = {a[2:0], 1'b0}; c = a[3]; end
            3'd6: begin r = {1'b0, a[3:1]}; c = a[0]; end
            default: return 7'b111_1010;
        endcase
        return {c, r[3], (r == 4'd0), r};
    endfunction

    assign {alu_cout, alu_neg, alu_zero, alu_result}     = alu_f(alu_a, alu_b, alu_sel);
    assign {alu_cout2, alu_neg2, alu_zero2, alu_result2} = alu_f(alu_a2, alu_b2, alu_sel2);

    alu_cmd_sequencer #(.N(N), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_neg(alu_neg), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_neg(rsp_neg), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .op_count(op_count), .err_count(err_count), .dbg_state(dbg_state)
    );

    alu_cmd_sequencer #(.N(N), .CW(2)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2),
        .alu_result(alu_result2), .alu_cout(alu_cout2), .alu_neg(alu_neg2), .alu_zero(alu_zero2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
        .rsp_cout(rsp_cout2), .rsp_neg(rsp_neg2), .rsp_zero(rsp_zero2), .rsp_err(rsp_err2),
        .op_count(op_count2), .err_count(err_count2), .dbg_state(dbg_state2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one operation in flight, response visible two edges
    // after acceptance, held until consumed.
    logic       m_exec = 1'b0, m_pend = 1'b0;
    logic [3:0] m_a = '0, m_b = '0, m_acc = '0, m_res = '0;
    logic [2:0] m_sel = '0;
    logic       m_c = 1'b0, m_n = 1'b0, m_z = 1'b0, m_e = 1'b0;
    int         m_ops = 0, m_errs = 0;
    logic [6:0] m_f;

    assign m_f = alu_f(m_a, m_b, m_sel);

    always @(posedge clk) begin
        if (rst) begin
            m_exec <= 1'b0; m_pend <= 1'b0;
            m_a <= '0; m_b <= '0; m_sel <= '0; m_acc <= '0;
            m_res <= '0; m_c <= 1'b0; m_n <= 1'b0; m_z <= 1'b0; m_e <= 1'b0;
            m_ops <= 0; m_errs <= 0;
        end else if (m_pend) begin
            if (rsp_ready) begin
                m_ops  <= m_ops + 1;
                m_errs <= m_errs + (m_e ? 1 : 0);
                m_pend <= 1'b0;
            end
        end else if (m_exec) begin
            if (m_sel == 3'b111) begin
                {m_c, m_n, m_z, m_res} <= 7'd0;
                m_e <= 1'b1;
            end else begin
                {m_c, m_n, m_z, m_res} <= m_f;
                m_acc <= m_f[3:0];
                m_e   <= 1'b0;
            end
            m_exec <= 1'b0;
            m_pend <= 1'b1;
        end else if (cmd_valid) begin
            m_a    <= cmd_chain ? m_acc : cmd_a;
            m_b    <= cmd_b;
            m_sel  <= cmd_op;
            m_exec <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmd_ready", cmd_ready, !(m_exec || m_pend));
            chk("cmd_ready2", cmd_ready2, !(m_exec || m_pend));
            chk("rsp_valid", rsp_valid, m_pend);
            chk("rsp_valid2", rsp_valid2, m_pend);
            chk("alu_ops", {alu_a, alu_b, alu_sel}, {m_a, m_b, m_sel});
            chk("alu_ops2", {alu_a2, alu_b2, alu_sel2}, {m_a, m_b, m_sel});
            chk("op_count", op_count, m_ops % 256);
            chk("err_count", err_count, (m_errs > 255) ? 255 : m_errs);
            chk("op_count2", op_count2, m_ops % 4);
            chk("err_count2", err_count2, (m_errs > 3) ? 3 : m_errs);
            if (m_pend) begin
                chk("rsp", {rsp_err, rsp_cout, rsp_neg, rsp_zero, rsp_result},
                    {m_e, m_c, m_n, m_z, m_res});
                chk("rsp2", {rsp_err2, rsp_cout2, rsp_neg2, rsp_zero2, rsp_result2},
                    {m_e, m_c, m_n, m_z, m_res});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns one cycle after the accepting edge (EXEC cycle).
    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic chain);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("cmd_accept_timeout", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic recv(input int hold);
        int n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        chk("rsp_timeout", rsp_valid, 1'b1);
        repeat (hold) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int ops_before;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_chain = 1'b0; rsp_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        chk_on = 1'b1;
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_alu", {alu_a, alu_b, alu_sel}, 11'd0);
        chk("reset_rsp", {rsp_err, rsp_cout, rsp_neg, rsp_zero, rsp_result}, 8'd0);
        chk("reset_counts", {op_count, err_count}, 16'd0);

        // Add 7+9: wraps to 0 with carry out.
        send(3'd0, 4'h7, 4'h9, 1'b0);
        chk("add_exec_a", alu_a, 4'h7);
        chk("add_exec_valid", rsp_valid, 1'b0);
        tick();
        chk("add_latency", rsp_valid, 1'b1);
        chk("add_result", rsp_result, 4'h0);
        chk("add_cout", rsp_cout, 1'b1);
        chk("add_zero", rsp_zero, 1'b1);
        recv(0);
        chk("add_op_count", op_count, 8'd1);

        // And C&A = 8, then chained xor with F = 7.
        send(3'd2, 4'hC, 4'hA, 1'b0);
        recv(0);
        send(3'd4, 4'h0, 4'hF, 1'b1);
        chk("chain_alu_a", alu_a, 4'h8);
        tick();
        chk("chain_xor_result", rsp_result, 4'h7);
        recv(0);

        // Illegal opcode: zeroed response, accumulator untouched.
        send(3'd7, 4'h3, 4'h3, 1'b0);
        tick();
        chk("illegal_rsp", {rsp_err, rsp_cout, rsp_neg, rsp_zero, rsp_result}, 8'h80);
        recv(1);
        chk("illegal_err_count", err_count, 8'd1);
        send(3'd0, 4'h0, 4'h1, 1'b1);
        chk("chain_after_err_a", alu_a, 4'h7);
        recv(0);
        chk("cw2_op_wrap", op_count2, 2'd1);

        // Back-pressure: response held for 10 cycles with the next command waiting.
        send(3'd0, 4'h1, 4'h2, 1'b0);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 4'h5; cmd_b = 4'h2; cmd_chain = 1'b0;
        ops_before = m_ops;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_rsp_result", rsp_result, 4'h3);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("hold_release_ready", cmd_ready, 1'b1);
        chk("hold_one_increment", op_count, ops_before + 1);
        tick();
        cmd_valid = 1'b0;
        chk("hold_next_alu_a", alu_a, 4'h5);
        recv(0);

        // Four more illegal ops: five in total saturates the 2-bit counter.
        for (int i = 0; i < 4; i++) begin
            send(3'd7, 4'(i), 4'(i + 1), 1'b0);
            recv(i);
        end
        chk("err_count_5", err_count, 8'd5);
        chk("cw2_err_sat", err_count2, 2'd3);
        chk("cw2_op_wrap_11", op_count2, 2'd3);

        // Remaining ops, including a response consumed on its first valid cycle.
        rsp_ready = 1'b1;
        send(3'd1, 4'h3, 4'h5, 1'b0);
        repeat (3) tick();
        rsp_ready = 1'b0;
        send(3'd5, 4'h9, 4'h0, 1'b0);
        tick();
        chk("shl_result", {rsp_cout, rsp_result}, 5'h12);
        recv(2);
        send(3'd6, 4'h9, 4'h0, 1'b0);
        recv(1);
        send(3'd3, 4'h0, 4'h6, 1'b1);
        recv(0);

        // Reset while a response is pending.
        send(3'd0, 4'h2, 4'h3, 1'b0);
        tick();
        chk("pre_reset_valid", rsp_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_rsp_valid", rsp_valid, 1'b0);
        chk("midreset_cmd_ready", cmd_ready, 1'b1);
        chk("midreset_counts", {op_count, err_count}, 16'd0);
        send(3'd0, 4'h9, 4'h0, 1'b1);
        chk("midreset_acc", alu_a, 4'h0);
        tick();
        chk("midreset_chain_result", {rsp_zero, rsp_result}, 5'h10);
        recv(0);
        chk("final_op_count", op_count, 8'd1);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
